// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, bubble insertion, flush and idle counter.
// Define PIPE_SKID_EN for a two-entry (output + skid) build with a registered d_ready.
module pipe_stage_reg #(
  parameter int unsigned      DATA_W  = 160,
  parameter int unsigned      CTL_W   = 9,
  parameter logic [CTL_W-1:0] CTL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTL_W-1:0]  d_ctl,
  input  logic              bubble,
  input  logic              flush,
  output logic              x_valid,
  input  logic              x_ready,
  output logic [DATA_W-1:0] x_data,
  output logic [CTL_W-1:0]  x_ctl,
  output logic [15:0]       idle_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTL_W-1:0]  out_ctl_q, out_ctl_d;
  logic [15:0]       idle_q, idle_d;
  logic              accept;
  logic              out_load;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTL_W-1:0]  skid_ctl_q, skid_ctl_d;

  // Ready comes from the skid-empty flop; bubble/flush/reset only gate it, x_ready never does.
  assign d_ready = rst && !skid_valid_q && !bubble && !flush;
`else
  assign d_ready = rst && !bubble && !flush && (!out_valid_q || x_ready);
`endif

  assign accept   = d_valid && d_ready;
  assign out_load = !out_valid_q || x_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ctl_d    = out_ctl_q;
`ifdef PIPE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctl_d   = skid_ctl_q;
`endif
    if (flush) begin
      out_valid_d  = 1'b0;
      out_ctl_d    = CTL_NOP;
`ifdef PIPE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (out_load) begin
`ifdef PIPE_SKID_EN
      // Older skid entry has priority over a bubble for the freed output slot.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_ctl_d    = skid_ctl_q;
        skid_valid_d = 1'b0;
      end else
`endif
      if (bubble) begin
        out_valid_d = 1'b1;
        out_ctl_d   = CTL_NOP;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = d_data;
        out_ctl_d   = d_ctl;
      end else begin
        out_valid_d = 1'b0;
      end
    end
`ifdef PIPE_SKID_EN
    else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = d_data;
      skid_ctl_d   = d_ctl;
    end
`endif
  end

  always_comb begin
    idle_d = idle_q;
    if (x_ready && (!out_valid_q || out_ctl_q == CTL_NOP) && idle_q != 16'hFFFF) begin
      idle_d = idle_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctl_q   <= CTL_NOP;
      idle_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ctl_q   <= out_ctl_d;
      idle_q      <= idle_d;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctl_q   <= CTL_NOP;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctl_q   <= skid_ctl_d;
    end
  end
`endif

  assign x_valid  = out_valid_q;
  assign x_data   = out_data_q;
  assign x_ctl    = out_ctl_q;
  assign idle_cnt = idle_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a queue-based reference model of the stage.
module tb_pipe_stage_reg;
  localparam int unsigned      DATA_W  = 160;
  localparam int unsigned      CTL_W   = 9;
  localparam logic [CTL_W-1:0] CTL_NOP = '0;
`ifdef PIPE_SKID_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              d_valid, d_ready, bubble, flush, x_valid, x_ready;
  logic [DATA_W-1:0] d_data, x_data;
  logic [CTL_W-1:0]  d_ctl, x_ctl;
  logic [15:0]       idle_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTL_W(CTL_W), .CTL_NOP(CTL_NOP)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .d_ctl(d_ctl), .bubble(bubble), .flush(flush), .x_valid(x_valid), .x_ready(x_ready),
    .x_data(x_data), .x_ctl(x_ctl), .idle_cnt(idle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTL_W-1:0]  c;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] m_data;
  logic [CTL_W-1:0]  m_ctl;
  int                m_idle;
  bit                m_acc;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = '0;
    m_ctl  = CTL_NOP;
    m_idle = 0;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    logic [31:0] w;
    for (int i = 0; i < int'(DATA_W); i++) begin
      w = $urandom;
      r[i] = w[0];
    end
    return r;
  endfunction

  function automatic logic [CTL_W-1:0] rand_ctl();
    logic [31:0] w;
    w = $urandom;
    return w[CTL_W-1:0];
  endfunction

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic dv, input logic [DATA_W-1:0] dd, input logic [CTL_W-1:0] dc,
                      input logic bub, input logic fl, input logic xr);
    bit   rdy;
    ent_t e;
    d_valid = dv; d_data = dd; d_ctl = dc; bubble = bub; flush = fl; x_ready = xr;
    #1;
    rdy = !bub && !fl && (mq.size() < Cap || (mq.size() == 1 && xr && Cap == 1));
    check_eq("d_ready", d_ready, rdy);
    m_acc = dv && rdy;
    if (xr && (mq.size() == 0 || m_ctl == CTL_NOP) && m_idle < 65535) m_idle++;
    if (fl) begin
      mq.delete();
      m_ctl = CTL_NOP;
    end else begin
      if (mq.size() > 0 && xr) void'(mq.pop_front());
      if (bub && mq.size() == 0) begin
        e.d = m_data; e.c = CTL_NOP;
        mq.push_back(e);
      end
      if (m_acc) begin
        e.d = dd; e.c = dc;
        mq.push_back(e);
      end
      if (mq.size() > 0) begin
        m_data = mq[0].d;
        m_ctl  = mq[0].c;
      end
    end
    @(posedge clk);
    #1;
    check_eq("x_valid", x_valid, mq.size() > 0);
    check_eq("x_data", x_data, m_data);
    check_eq("x_ctl", x_ctl, m_ctl);
    check_eq("idle_cnt", idle_cnt, m_idle[15:0]);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x_valid"}, x_valid, 1'b0);
    check_eq({tag, "_x_data"}, x_data, '0);
    check_eq({tag, "_x_ctl"}, x_ctl, CTL_NOP);
    check_eq({tag, "_idle"}, idle_cnt, 16'd0);
    check_eq({tag, "_d_ready"}, d_ready, 1'b0);
  endtask

  initial begin
    int k;
    int exp_seq;
    int guard;
    bit xr;
    rst = 1'b0;
    d_valid = 1'b1; d_data = '0; d_ctl = '0; bubble = 1'b0; flush = 1'b0; x_ready = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // First accept on the first edge after reset release
    step(1'b1, 160'h1234, 9'h1FF, 1'b0, 1'b0, 1'b1);
    check_eq("first_valid", x_valid, 1'b1);
    check_eq("first_data", x_data, 160'h1234);
    check_eq("first_ctl", x_ctl, 9'h1FF);
    check_eq("first_idle", idle_cnt, 16'd1);

    // Drain, then stream 1..8 with x_ready pattern 1,0,0,1
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    k = 1; exp_seq = 1; guard = 0;
    while ((k <= 8 || x_valid) && guard < 100) begin
      case (guard % 4)
        0, 3: xr = 1'b1;
        default: xr = 1'b0;
      endcase
      if (k > 8) xr = 1'b1;
      if (x_valid && xr) begin
        check_eq("stream_order", x_data, exp_seq);
        exp_seq++;
      end
      step(k <= 8, k, k[CTL_W-1:0] + 9'd1, 1'b0, 1'b0, xr);
      if (m_acc) k++;
      guard++;
    end
    check_eq("stream_count", exp_seq, 9);

    // One-cycle bubble during a free-flowing stream
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 160'h100 + i, 9'h011, i == 2, 1'b0, 1'b1);
    end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Fill all storage while stalled, then flush with d_valid and bubble high
    for (int i = 0; i < 3; i++) step(1'b1, 160'h200 + i, 9'h022, 1'b0, 1'b0, 1'b0);
    step(1'b1, 160'h2FF, 9'h033, 1'b1, 1'b1, 1'b0);
    check_eq("flush_valid", x_valid, 1'b0);
    check_eq("flush_ctl", x_ctl, CTL_NOP);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("flush_empty", x_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_data(), rand_ctl(), $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    // Idle counter saturation
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    d_valid = 1'b0; bubble = 1'b0; flush = 1'b0; x_ready = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    m_idle = (m_idle + 70000 > 65535) ? 65535 : m_idle + 70000;
    check_eq("idle_sat", idle_cnt, 16'hFFFF);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("idle_hold", idle_cnt, 16'hFFFF);

    // Asynchronous reset in the middle of a stalled stream
    for (int i = 0; i < 3; i++) step(1'b1, 160'h300 + i, 9'h044, 1'b0, 1'b0, 1'b0);
    d_valid = 1'b1; x_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 160'h4321, 9'h055, 1'b0, 1'b0, 1'b1);
    check_eq("post_rst_data", x_data, 160'h4321);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160, width of datapath payload (pcp4, operands, immediate, register specifiers packed).
REQ-002 SHALL have parameter CTL_W, default 9, width of control payload (WB/M/EX fields packed).
REQ-003 SHALL have parameter CTL_NOP, default 0, control value meaning "no side effects" (bubble).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 d_valid  input  1  upstream stage presents an entry.
REQ-007 d_ready  output  1  stage can accept an entry this cycle.
REQ-008 d_data  input  DATA_W  upstream datapath payload.
REQ-009 d_ctl  input  CTL_W  upstream control payload.
REQ-010 bubble  input  1  hazard unit requests a NOP insertion instead of upstream entry.
REQ-011 flush  input  1  discard all held entries (branch/exception).
REQ-012 x_valid  output  1  stage presents an entry downstream.
REQ-013 x_ready  input  1  downstream accepts the presented entry.
REQ-014 x_data  output  DATA_W  held datapath payload, registered.
REQ-015 x_ctl  output  CTL_W  held control payload, registered.
REQ-016 idle_cnt  output  16  saturating count of bubble/empty cycles seen downstream.

Function
REQ-017 Accept occurs when d_valid && d_ready; release occurs when x_valid && x_ready.
REQ-018 An accepted entry SHALL appear on x_valid/x_data/x_ctl exactly 1 cycle after accept when the output slot is free or releasing.
REQ-019 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-020 x_data and x_ctl SHALL hold stable while x_valid && !x_ready.
REQ-021 bubble=1 SHALL force d_ready=0 and, if the output slot is free or releasing, load a valid entry with x_ctl=CTL_NOP and x_data unchanged.
REQ-022 bubble with output slot full and not releasing SHALL have no effect that cycle (hazard unit holds bubble).
REQ-023 flush=1 SHALL force d_ready=0 and on the next edge set x_valid=0, x_ctl=CTL_NOP, and empty all internal entries; flush beats bubble, accept and release in the same cycle.
REQ-024 Simultaneous accept and release on a full single slot SHALL replace the entry with no idle cycle (full throughput).
REQ-025 idle_cnt SHALL increment each cycle where x_ready=1 and (x_valid=0 or x_ctl=CTL_NOP), saturating at 16'hFFFF, never wrapping.

Reset
REQ-026 While rst=0: x_valid=0, x_data=0, x_ctl=CTL_NOP, idle_cnt=0, d_ready=0, all internal entries empty, asynchronously.
REQ-027 Reset asserted mid-transfer SHALL discard the entry; first accept possible on the first edge after rst rises, with d_ready=1 in that cycle.

Configuration
REQ-028 Macro PIPE_SKID_EN SHALL select storage: defined -> two entries (output + skid), d_ready driven directly from a flop (= skid empty), no combinational x_ready->d_ready path; entry accepted while output stalled goes to skid and moves to output on next release.
REQ-029 Without PIPE_SKID_EN -> single entry, d_ready = !bubble && !flush && (!x_valid || x_ready), combinational from x_ready.
REQ-030 Functional ordering, latency (REQ-018) and flush/bubble behaviour SHALL be identical in both builds; only d_ready timing and storage differ.

Verification
REQ-031 Reset release, d_valid=1 d_data=0x1234 d_ctl=0x1FF, x_ready=1 -> x_valid=1, x_data=0x1234, x_ctl=0x1FF one cycle later; idle_cnt=1 after the first empty cycle.
REQ-032 Stream 8 entries 1..8 with x_ready toggling 1,0,0,1... -> outputs 1..8 in order, no loss/duplication, x_data stable during x_ready=0; with PIPE_SKID_EN, d_ready falls only after skid fills.
REQ-033 bubble=1 for one cycle during stream -> one entry with x_ctl=CTL_NOP inserted, next upstream entry follows unmodified; idle_cnt increments once.
REQ-034 flush=1 with skid and output both full and d_valid=1, bubble=1 -> next cycle x_valid=0, x_ctl=CTL_NOP, both entries gone, nothing accepted.
REQ-035 Hold x_valid=0, x_ready=1 for 70000 cycles -> idle_cnt stops at 0xFFFF; rst low mid-stream -> all outputs reset values immediately, without a clock edge.
